// File: rtl/ccff_load_ctrl.sv
// ---------------------------------------------------------------------------
// ccff_load_ctrl
//   Sequences an FPGA configuration load. It pulses pReset, reads a bit-length
//   header (word 0) and then the bitstream words (1..W) from PMU-side memory.
//   Each word is shifted LSB first into the fabric configuration chain with a
//   generated prog_clk. When the load completes, fabric reset is released and
//   the fabric clock is enabled.
//
// Ports
//   clk_i, rst_i        system clock, asynchronous active-low reset
//   start_i, abort_i    load request (accepted in IDLE/DONE/ERR), sync abort
//   busy_o/done_o/err_o status (done/err held until next accepted start)
//   mem_rd_o/mem_addr_o read strobe and address; mem_data_i valid next cycle
//   prog_clk_o          configuration shift clock (registered, glitch-free)
//   ccff_head_o         serial configuration data (registered)
//   preset_o            active-high pReset pulse
//   fpga_rst_o          active-high fabric reset (low only in DONE)
//   fpga_clk_en_o       fabric clock enable (high only in DONE)
// ---------------------------------------------------------------------------
module ccff_load_ctrl #(
    parameter int PRESET_CYCLES = 4,
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 32,
    parameter int CNT_W         = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              prog_clk_o,
    output logic              ccff_head_o,
    output logic              preset_o,
    output logic              fpga_rst_o,
    output logic              fpga_clk_en_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRESET, S_HDR_RD, S_HDR_WAIT, S_WD_RD,
        S_WD_LATCH, S_SH_LO, S_SH_HI, S_DONE, S_ERR
    } state_e;

    localparam int              PC_W    = (PRESET_CYCLES > 1) ? $clog2(PRESET_CYCLES) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESET_CYCLES - 1);
    // Largest word count that fits in the address space above the header.
    localparam logic [CNT_W:0]  W_MAX   = (CNT_W+1)'((1 << ADDR_W) - 1);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pcnt_q, pcnt_d;
    logic [CNT_W-1:0]    rem_q, rem_d;      // bits left in the whole load
    logic [5:0]          bcnt_q, bcnt_d;    // bits left in the current word
    logic [ADDR_W-1:0]   word_q, word_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]    hdr_n;
    logic [CNT_W:0]      hdr_w;

    logic busy_q, done_q, err_q, rd_q, pclk_q, head_q, preset_q, frst_q, fen_q;
    logic head_d;
    logic [ADDR_W-1:0] addr_q;

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        rem_d   = rem_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        sr_d    = sr_q;
        hdr_n   = mem_data_i[CNT_W-1:0];
        hdr_w   = ({1'b0, hdr_n} + (CNT_W+1)'(31)) >> 5;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_PRESET;
                    pcnt_d  = '0;
                end
            end
            S_PRESET: begin
                if (pcnt_q == PC_LAST) state_d = S_HDR_RD;
                else                   pcnt_d  = pcnt_q + PC_W'(1);
            end
            S_HDR_RD:   state_d = S_HDR_WAIT;
            S_HDR_WAIT: begin
                if (hdr_n == '0 || hdr_w > W_MAX) begin
                    state_d = S_ERR;
                end else begin
                    rem_d   = hdr_n;
                    word_d  = ADDR_W'(1);
                    state_d = S_WD_RD;
                end
            end
            S_WD_RD:    state_d = S_WD_LATCH;
            S_WD_LATCH: begin
                sr_d    = mem_data_i;
                bcnt_d  = (rem_q >= CNT_W'(32)) ? 6'd32 : rem_q[5:0];
                state_d = S_SH_LO;
            end
            S_SH_LO:    state_d = S_SH_HI;
            S_SH_HI: begin
                sr_d   = {1'b0, sr_q[DATA_W-1:1]};
                rem_d  = rem_q - CNT_W'(1);
                bcnt_d = bcnt_q - 6'd1;
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end else if (bcnt_q == 6'd1) begin
                    word_d  = word_q + ADDR_W'(1);
                    state_d = S_WD_RD;
                end else begin
                    state_d = S_SH_LO;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything outside IDLE (an SH_HI edge has already
        // been presented, so it completes naturally).
        if (abort_i && state_q != S_IDLE) state_d = S_ERR;

        // Chain data presented in SH_LO and held through SH_HI.
        unique case (state_d)
            S_SH_LO: head_d = sr_d[0];
            S_SH_HI: head_d = head_q;
            default: head_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            pcnt_q  <= '0;
            rem_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            rem_q   <= rem_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            sr_q    <= sr_d;
        end
    end

    // All outputs are registered decodes of the next state, so each output
    // reflects the state occupied in the same cycle and cannot glitch.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            pclk_q   <= 1'b0;
            head_q   <= 1'b0;
            preset_q <= 1'b0;
            frst_q   <= 1'b1;
            fen_q    <= 1'b0;
        end else begin
            busy_q   <= !(state_d inside {S_IDLE, S_DONE, S_ERR});
            done_q   <= (state_d == S_DONE);
            err_q    <= (state_d == S_ERR);
            rd_q     <= (state_d == S_HDR_RD) || (state_d == S_WD_RD);
            addr_q   <= (state_d == S_WD_RD) ? word_d : '0;
            pclk_q   <= (state_d == S_SH_HI);
            head_q   <= head_d;
            preset_q <= (state_d == S_PRESET);
            frst_q   <= (state_d != S_DONE);
            fen_q    <= (state_d == S_DONE);
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign mem_rd_o      = rd_q;
    assign mem_addr_o    = addr_q;
    assign prog_clk_o    = pclk_q;
    assign ccff_head_o   = head_q;
    assign preset_o      = preset_q;
    assign fpga_rst_o    = frst_q;
    assign fpga_clk_en_o = fen_q;

endmodule

// File: tb/tb_ccff_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ccff_load_ctrl
//   Self-checking bench for ccff_load_ctrl. A behavioural memory supplies the
//   header and random bitstream words; expected chain contents, read sequence
//   and completion cycle are derived directly from the load rules.
// ---------------------------------------------------------------------------
module tb_ccff_load_ctrl;
    localparam int P = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        busy_o, done_o, err_o, mem_rd_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_data_i = '0;
    logic        prog_clk_o, ccff_head_o, preset_o, fpga_rst_o, fpga_clk_en_o;

    ccff_load_ctrl #(.PRESET_CYCLES(P), .ADDR_W(8), .DATA_W(32), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .prog_clk_o(prog_clk_o), .ccff_head_o(ccff_head_o), .preset_o(preset_o),
        .fpga_rst_o(fpga_rst_o), .fpga_clk_en_o(fpga_clk_en_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory with one-cycle read latency
    logic [31:0] mem [0:255];
    always @(posedge clk_i) if (mem_rd_o) mem_data_i <= mem[mem_addr_o];

    int errors = 0;
    int checks = 0;

    // Observations from the most recent load
    int   cyc_done, cyc_err, n_rise, preset_cnt, busy_gap;
    bit   timed_out;
    logic [4:0] c1_flags;
    logic got_bits[$];
    int   rd_addr[$];

    // Runs one load from a start pulse and records what the DUT does, one
    // sample per cycle on the falling edge (cycle 0 = start sampled).
    task automatic do_load(input int abort_at, input int pulse_at, input int budget);
        logic pprev;
        int   cyc;
        cyc_done = -1; cyc_err = -1; n_rise = 0; preset_cnt = 0; busy_gap = 0;
        timed_out = 0; c1_flags = 'x;
        got_bits.delete(); rd_addr.delete();
        @(negedge clk_i);
        start_i = 1'b1;
        cyc = 0;
        pprev = prog_clk_o;
        while (1) begin
            @(negedge clk_i);
            cyc++;
            start_i = 1'b0;
            abort_i = 1'b0;
            if (cyc == 1) c1_flags = {done_o, err_o, fpga_rst_o, fpga_clk_en_o, busy_o};
            if (preset_o) preset_cnt++;
            if (mem_rd_o) rd_addr.push_back(int'(mem_addr_o));
            if (prog_clk_o && !pprev) begin
                got_bits.push_back(ccff_head_o);
                n_rise++;
            end
            pprev = prog_clk_o;
            if (done_o) begin cyc_done = cyc; break; end
            if (err_o)  begin cyc_err  = cyc; break; end
            if (!busy_o) busy_gap++;
            if (cyc >= budget) begin timed_out = 1; break; end
            if (abort_at > 0 && n_rise == abort_at && prog_clk_o) abort_i = 1'b1;
            if (pulse_at >= 0 && n_rise == pulse_at && !prog_clk_o) start_i = 1'b1;
        end
    endtask

    task automatic fill_mem(input int n, input logic [15:0] hi);
        int w;
        w = (n + 31) / 32;
        mem[0] = {hi, n[15:0]};
        for (int k = 1; k <= w && k < 256; k++) mem[k] = $urandom;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, err_o, mem_rd_o, prog_clk_o, ccff_head_o, preset_o,
             fpga_rst_o, fpga_clk_en_o} !== 9'b0000_0001_0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000010",
                {busy_o, done_o, err_o, mem_rd_o, prog_clk_o, ccff_head_o, preset_o,
                 fpga_rst_o, fpga_clk_en_o});
        end
        checks++;
        if (mem_addr_o !== 8'd0) begin
            errors++; $display("FAIL reset_addr: got %0d want 0", mem_addr_o);
        end
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({busy_o, preset_o, mem_rd_o, fpga_rst_o} !== 4'b0001) begin
            errors++;
            $display("FAIL idle_hold: got %b want 0001", {busy_o, preset_o, mem_rd_o, fpga_rst_o});
        end
    endtask

    task automatic test_load(input int n, input logic [15:0] hi, input int pulse_at);
        int w, exp_done, bad;
        logic eb;
        w = (n + 31) / 32;
        exp_done = P + 3 + 2 * w + 2 * n;
        fill_mem(n, hi);
        do_load(-1, pulse_at, exp_done + 20);

        checks++;
        if (timed_out || cyc_done != exp_done) begin
            errors++;
            $display("FAIL n%0d done_cycle: got %0d want %0d (timeout=%0d)", n, cyc_done, exp_done, timed_out);
        end
        checks++;
        if (n_rise != n) begin
            errors++; $display("FAIL n%0d prog_clk_rises: got %0d want %0d", n, n_rise, n);
        end
        checks++;
        if (rd_addr.size() != w + 1) begin
            errors++; $display("FAIL n%0d read_count: got %0d want %0d", n, rd_addr.size(), w + 1);
        end
        bad = 0;
        foreach (rd_addr[i]) if (rd_addr[i] != i) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL n%0d read_addrs: got %0d out-of-order want 0", n, bad);
        end
        bad = 0;
        for (int i = 0; i < n && i < got_bits.size(); i++) begin
            eb = mem[1 + i / 32][i % 32];
            if (got_bits[i] !== eb) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL n%0d chain_bits: got %0d wrong bits want 0", n, bad);
        end
        checks++;
        if (preset_cnt != P || busy_gap != 0) begin
            errors++;
            $display("FAIL n%0d preset_busy: got preset=%0d gap=%0d want %0d/0", n, preset_cnt, busy_gap, P);
        end
        checks++;
        if (c1_flags !== 5'b00101) begin
            errors++; $display("FAIL n%0d cycle1_flags: got %b want 00101", n, c1_flags);
        end
        repeat (3) @(negedge clk_i);
        checks++;
        if ({done_o, err_o, busy_o, fpga_rst_o, fpga_clk_en_o, prog_clk_o, preset_o, mem_rd_o}
                !== 8'b1000_1000) begin
            errors++;
            $display("FAIL n%0d done_hold: got %b want 10001000", n,
                {done_o, err_o, busy_o, fpga_rst_o, fpga_clk_en_o, prog_clk_o, preset_o, mem_rd_o});
        end
    endtask

    task automatic test_bad_header(input logic [31:0] hdr);
        mem[0] = hdr;
        do_load(-1, -1, 50);
        checks++;
        if (cyc_err != P + 3) begin
            errors++; $display("FAIL hdr%08h err_cycle: got %0d want %0d", hdr, cyc_err, P + 3);
        end
        checks++;
        if (n_rise != 0 || rd_addr.size() != 1) begin
            errors++;
            $display("FAIL hdr%08h activity: got rises=%0d reads=%0d want 0/1", hdr, n_rise, rd_addr.size());
        end
        checks++;
        if ({fpga_rst_o, fpga_clk_en_o, done_o, busy_o} !== 4'b1000) begin
            errors++;
            $display("FAIL hdr%08h err_outputs: got %b want 1000", hdr, {fpga_rst_o, fpga_clk_en_o, done_o, busy_o});
        end
    endtask

    task automatic test_abort();
        int j, exp_err, bad;
        logic eb;
        fill_mem(548, 16'h0);
        do_load(100, -1, 2000);
        j = 99;
        exp_err = P + 3 + 2 * (j / 32 + 1) + 2 * (j + 1);
        checks++;
        if (n_rise != 100 || cyc_err != exp_err) begin
            errors++;
            $display("FAIL abort_rises: got rises=%0d err_cyc=%0d want 100/%0d", n_rise, cyc_err, exp_err);
        end
        bad = 0;
        for (int i = 0; i < got_bits.size() && i < 100; i++) begin
            eb = mem[1 + i / 32][i % 32];
            if (got_bits[i] !== eb) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL abort_bits: got %0d wrong want 0", bad);
        end
        @(negedge clk_i);
        checks++;
        if ({err_o, fpga_rst_o, fpga_clk_en_o, prog_clk_o, busy_o} !== 5'b11000) begin
            errors++;
            $display("FAIL abort_outputs: got %b want 11000", {err_o, fpga_rst_o, fpga_clk_en_o, prog_clk_o, busy_o});
        end
    endtask

    task automatic test_reset_mid_load();
        fill_mem(548, 16'h0);
        do_load(-1, -1, 300);       // still shifting when the budget runs out
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, err_o, mem_rd_o, prog_clk_o, ccff_head_o, preset_o,
             fpga_rst_o, fpga_clk_en_o} !== 9'b0000_0001_0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b want 000000010",
                {busy_o, done_o, err_o, mem_rd_o, prog_clk_o, ccff_head_o, preset_o,
                 fpga_rst_o, fpga_clk_en_o});
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        test_load(300, 16'h0, -1);
    endtask

    task automatic test_done_abort();
        // DONE held from the previous load; abort and start together -> ERR
        @(negedge clk_i);
        start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; abort_i = 1'b0;
        checks++;
        if ({err_o, done_o, busy_o, preset_o, fpga_rst_o, fpga_clk_en_o} !== 6'b100010) begin
            errors++;
            $display("FAIL done_abort: got %b want 100010",
                {err_o, done_o, busy_o, preset_o, fpga_rst_o, fpga_clk_en_o});
        end
        repeat (3) @(negedge clk_i);
        checks++;
        if ({err_o, busy_o} !== 2'b10) begin
            errors++; $display("FAIL err_hold: got %b want 10", {err_o, busy_o});
        end
    endtask

    initial begin
        test_reset();
        test_load(548, 16'h0, -1);
        test_load(256, 16'h0, -1);
        test_load(257, 16'hFFFF, -1);
        test_bad_header(32'h0000_0000);
        test_bad_header(32'hA5A5_0000);   // upper bits ignored, N=0
        test_bad_header(32'h0000_1FE1);   // 8161 -> W=256
        test_load(8160, 16'h0, -1);       // from ERR
        test_load(548, 16'h0, 10);        // stray start mid-shift
        for (int r = 0; r < 3; r++)
            test_load(int'($urandom_range(1, 1500)), 16'($urandom), -1);
        test_done_abort();
        test_abort();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
